ifft8_seq: RTL and testbench
============================

# ifft8_seq

Sequential 8-point radix-2 decimation-in-time inverse FFT engine. It accepts eight complex frequency-domain bins over a valid/ready stream and computes the time-domain samples with one shared butterfly, one butterfly per cycle. Results stream out in natural order. It is the return path for the combinational forward 8-point FFT and uses the same signed Q16.16 32-bit number format.

## Interface
- `N`, default 8: transform length; fixed, and only 8 is supported.
- `W`, default 32: sample width per real/imag component, signed Q16.16.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input bin present.
- `in_ready`  out  1  engine accepts a bin this cycle.
- `in_re`, `in_im`  in  W  bin X[k]; bins arrive in order k=0..7.
- `out_valid`  out  1  output sample present.
- `out_ready`  in  1  sink accepts a sample.
- `out_re`, `out_im`  out  W  sample x[n]; samples leave in order n=0..7.
- `out_last`  out  1  high with x[7].
- `busy`  out  1  high in COMPUTE and UNLOAD.

## Operation
- States and transitions:
  - LOAD: `in_ready`=1. Each `in_valid&&in_ready` writes the bin to `buf[bitrev3(k)]` and increments `k`. Acceptance at k=7 moves to COMPUTE.
  - COMPUTE: 3 stages, h = 1, 2, 4. Each stage runs 4 butterflies in index order, one per cycle, 12 cycles total, then moves to UNLOAD.
  - UNLOAD: presents `buf[n]`. Each `out_valid&&out_ready` increments `n`. Handshake at n=7 returns to LOAD.
- Butterfly on pair (a, b), where b = a+h:
  - t = W·b, then a' = a+t and b' = a−t.
  - W = exp(+j2πm/8) with m = j·(4/h), j = position within the group.
  - Table (re, im): m0 (0x10000, 0), m1 (0xB505, 0xB505), m2 (0, 0x10000), m3 (−0xB505, 0xB505).
- Complex multiply: four 32×32 signed products to 64 bits. Real part = rr−ii, imag part = ri+ir, each taking bits [47:16] with truncation (no rounding).
- Add/subtract: W-bit two's complement, wrap on overflow, no saturation.
- In-place update: both results are written back to `buf` in the same cycle.
- `in_valid` is ignored outside LOAD. `out_ready` is ignored outside UNLOAD.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_re`/`out_im`=0, state LOAD, k=n=0. Buffer contents are don't-care.
- Handshake rules:
  - Input gaps (`in_valid` low) simply stall LOAD.
  - `out_valid` is registered. While `out_ready`=0, `out_valid`, `out_re`, `out_im` and `out_last` hold stable.
- Latency:
  - The cycle after the 8th input handshake is COMPUTE cycle 1.
  - `out_valid` rises on the cycle after the 12th compute cycle, i.e. 13 cycles after the last input handshake.
- Throughput: minimum 8 + 12 + 8 = 28 cycles per frame. Input and output do not overlap.
- `in_ready` and `out_valid` are never high together.
- Reset in any state aborts the frame within one cycle and restores reset values. A partial frame is discarded.

## Configuration
- `IFFT8_SCALE_EN` defined: every butterfly output is arithmetic-shifted right by 1 before write-back, giving a total scale of 1/8. Outputs equal the true IDFT, x[n] = (1/8)·ΣX[k]e^{+j2πkn/8}.
- `IFFT8_SCALE_EN` undefined: no shifts, outputs equal 8·x[n], and overflow wraps.
- Latency and handshakes are identical in both builds.

## Structure
- Shared package `fft_pkg`:
  - Q16.16 width and fraction constants.
  - Twiddle constants m0..m3 as listed above.
  - Complex type (re/im pair).
  - State enumeration.
  - `bitrev3` function.
- Sub-module `ifft_bfly`: a combinational butterfly (a, b, W) → (a', b'). It contains the complex multiply and the conditional shift under `IFFT8_SCALE_EN`. It is instantiated once.
- The top level holds `buf[0:7]`, the counters, the FSM and the stage/butterfly address generator.

## Test plan
- Scaled build: impulse X[0]=0x80000 (8.0), all other bins 0 → all eight outputs re=0x10000, im=0, and `out_last` asserts on n=7.
- Scaled build: X[1]=0x80000, others 0 → x[0]=(0x10000,0), x[2]=(0,0x10000), x[4]=(−0x10000,0), x[1]≈(0xB505,0xB505) within ±2 LSB.
- Unscaled build: X[k]=0x10000 for all k → x[0]=(0x80000,0) and x[1..7]=0.
- Backpressure: hold `out_ready`=0 for 3 cycles at n=3 → x[3] stays stable with `out_valid`=1, then the remaining samples appear in order. Separately, random `in_valid` gaps → identical results.
- Reset at COMPUTE cycle 5 → next cycle `busy`=0 and `in_ready`=1. A fresh impulse frame then yields correct outputs with no residue from the aborted frame.
- Latency check: count cycles from the 8th input handshake to `out_valid` rising, expecting exactly 13. Run two back-to-back frames to confirm the 28-cycle minimum frame period.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared Q16.16 constants, complex type, FSM states and bit-reversal helper
package fft_pkg;

  localparam int Q_W    = 32;
  localparam int Q_FRAC = 16;

  localparam logic signed [Q_W-1:0] TW_ONE = 32'sh0001_0000;
  localparam logic signed [Q_W-1:0] TW_R2  = 32'sh0000_B505;

  typedef struct packed {
    logic signed [Q_W-1:0] re;
    logic signed [Q_W-1:0] im;
  } cplx_t;

  localparam cplx_t TW_M0 = '{re: TW_ONE, im: '0};
  localparam cplx_t TW_M1 = '{re: TW_R2,  im: TW_R2};
  localparam cplx_t TW_M2 = '{re: '0,     im: TW_ONE};
  localparam cplx_t TW_M3 = '{re: -TW_R2, im: TW_R2};

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_UNLOAD
  } state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  function automatic cplx_t twiddle(input logic [1:0] m);
    case (m)
      2'd0:    return TW_M0;
      2'd1:    return TW_M1;
      2'd2:    return TW_M2;
      default: return TW_M3;
    endcase
  endfunction

endpackage

// File: rtl/ifft8_seq_if.sv
// rtl/ifft8_seq_if.sv - input bin stream and output sample stream of the 8-point IFFT
interface ifft8_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic         out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/ifft_bfly.sv
// rtl/ifft_bfly.sv - combinational radix-2 DIT butterfly a'=a+Wb, b'=a-Wb
// IFFT8_SCALE_EN: halves both outputs before write-back.
module ifft_bfly
  import fft_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t w,
  output cplx_t a_o,
  output cplx_t b_o
);
  logic signed [63:0] b_re, b_im, w_re, w_im;
  logic signed [63:0] t_re64, t_im64;
  cplx_t t, sum, dif;

  always_comb begin
    b_re   = {{32{b.re[Q_W-1]}}, b.re};
    b_im   = {{32{b.im[Q_W-1]}}, b.im};
    w_re   = {{32{w.re[Q_W-1]}}, w.re};
    w_im   = {{32{w.im[Q_W-1]}}, w.im};
    t_re64 = b_re * w_re - b_im * w_im;
    t_im64 = b_re * w_im + b_im * w_re;
    // Q16.16 x Q16.16 -> keep bits [47:16], truncating
    t.re   = Q_W'(t_re64 >>> Q_FRAC);
    t.im   = Q_W'(t_im64 >>> Q_FRAC);
    sum.re = a.re + t.re;
    sum.im = a.im + t.im;
    dif.re = a.re - t.re;
    dif.im = a.im - t.im;
`ifdef IFFT8_SCALE_EN
    a_o.re = sum.re >>> 1;
    a_o.im = sum.im >>> 1;
    b_o.re = dif.re >>> 1;
    b_o.im = dif.im >>> 1;
`else
    a_o    = sum;
    b_o    = dif;
`endif
  end
endmodule

// File: rtl/ifft8_seq.sv
// rtl/ifft8_seq.sv - sequential 8-point inverse FFT, one shared butterfly per cycle
// IFFT8_SCALE_EN (in ifft_bfly) selects the 1/8-scaled output build.
module ifft8_seq
  import fft_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       rst,
  ifft8_seq_if.slave io,
  output logic       busy
);
  localparam logic [2:0] K_LAST = 3'(N - 1);

  state_t       state, state_nx;
  cplx_t        mem [0:7];
  logic [2:0]   k_q, n_q;
  logic [3:0]   cnt_q;
  logic         out_valid_q, out_last_q;
  logic [W-1:0] out_re_q, out_im_q;
  logic         in_fire, out_fire, cnt_last;
  logic [1:0]   stg, bi, tw_m;
  logic [2:0]   idx_a, idx_b;
  cplx_t        tw, bf_a, bf_b;

  assign in_fire      = (state == ST_LOAD) && io.in_valid;
  assign out_fire     = (state == ST_UNLOAD) && out_valid_q && io.out_ready;
  assign cnt_last     = (cnt_q == 4'd11);
  assign io.in_ready  = (state == ST_LOAD);
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.out_re    = out_re_q;
  assign io.out_im    = out_im_q;
  assign busy         = (state != ST_LOAD);

  // cnt_q = {stage, butterfly}; pair (a, a+h) with h = 1 << stage
  always_comb begin
    stg   = cnt_q[3:2];
    bi    = cnt_q[1:0];
    idx_a = '0;
    idx_b = '0;
    tw_m  = '0;
    case (stg)
      2'd0: begin
        idx_a = {bi, 1'b0};
        idx_b = {bi, 1'b1};
        tw_m  = 2'd0;
      end
      2'd1: begin
        idx_a = {bi[1], 1'b0, bi[0]};
        idx_b = {bi[1], 1'b1, bi[0]};
        tw_m  = {bi[0], 1'b0};
      end
      default: begin
        idx_a = {1'b0, bi};
        idx_b = {1'b1, bi};
        tw_m  = bi;
      end
    endcase
  end

  assign tw = twiddle(tw_m);

  ifft_bfly u_bfly (
    .a   (mem[idx_a]),
    .b   (mem[idx_b]),
    .w   (tw),
    .a_o (bf_a),
    .b_o (bf_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:    if (in_fire && k_q == K_LAST) state_nx = ST_COMPUTE;
      ST_COMPUTE: if (cnt_last)                 state_nx = ST_UNLOAD;
      ST_UNLOAD:  if (out_fire && n_q == 3'd7)  state_nx = ST_LOAD;
      default:                                  state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[bitrev3(k_q)] <= '{re: Q_W'(io.in_re), im: Q_W'(io.in_im)};
    end else if (state == ST_COMPUTE) begin
      mem[idx_a] <= bf_a;
      mem[idx_b] <= bf_b;
    end
  end

  // x[0] is final well before the last butterfly (pair 3,7), so it can be staged then
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      if (in_fire) k_q <= k_q + 3'd1;
      if (state == ST_COMPUTE) begin
        cnt_q <= cnt_last ? 4'd0 : cnt_q + 4'd1;
        if (cnt_last) begin
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b0;
          out_re_q    <= W'(mem[0].re);
          out_im_q    <= W'(mem[0].im);
        end
      end
      if (out_fire) begin
        n_q <= n_q + 3'd1;
        if (n_q == 3'd7) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end else begin
          out_re_q   <= W'(mem[n_q + 3'd1].re);
          out_im_q   <= W'(mem[n_q + 3'd1].im);
          out_last_q <= (n_q == 3'd6);
        end
      end
    end
  end
endmodule

// File: tb/tb_ifft8_seq.sv
// tb/tb_ifft8_seq.sv - table-driven and randomized bench for ifft8_seq against a direct IDFT model
module tb_ifft8_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifft8_seq_if #(.W(32)) io ();

  ifft8_seq #(.N(8), .W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io),
    .busy (busy)
  );

  typedef struct packed {
    logic [7:0][31:0] xr;
    logic [7:0][31:0] xi;
    logic [7:0][31:0] er;
    logic [7:0][31:0] ei;
  } vec_t;

  vec_t tbl [5];
  int   x_re [8];
  int   x_im [8];
  int   got_re [8];
  int   got_im [8];
  int   sav_re [8];
  int   sav_im [8];
  int   first_hs, last_hs, lat;

  task automatic chk(input string nm, input longint got, input longint exp, input longint tol);
    longint d;
    d = got - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, got, exp, tol);
    end
  endtask

  task automatic chk_r(input string nm, input int got, input real exp, input real tol);
    real d;
    d = real'(got) - exp;
    if (d < 0.0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0f (tol %0f)", nm, got, exp, tol);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (io.in_ready && io.out_valid) begin
        errors++;
        $display("FAIL ready_valid_excl: got in_ready=1 out_valid=1, expected not both at cycle %0d", cyc);
      end
    end
  end

  function automatic int rnd();
    return int'($urandom) >>> 13;
  endfunction

  task automatic load_frame(input int gap_pct);
    int k = 0;
    int t = 0;
    while (k < 8 && t < 400) begin
      io.in_valid = ($urandom_range(99) >= gap_pct);
      io.in_re    = x_re[k];
      io.in_im    = x_im[k];
      @(negedge clk);
      if (io.in_valid && io.in_ready) begin
        if (k == 0) first_hs = cyc;
        last_hs = cyc;
        k++;
      end
      @(posedge clk); #1;
      t++;
    end
    io.in_valid = 1'b0;
    chk("load_count", k, 8, 0);
  endtask

  task automatic unload_frame(input int stall_pct, input int hold_n);
    int          n = 0;
    int          t = 0;
    int          h = 0;
    bit          seen = 0;
    bit          held = 0;
    logic [31:0] hre, him;
    logic        hlast;
    lat = -1;
    while (n < 8 && t < 400) begin
      if (n == hold_n && h < 3) io.out_ready = 1'b0;
      else                      io.out_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (io.out_valid && !seen) begin
        seen = 1;
        lat  = cyc - last_hs;
      end
      if (n == hold_n && held) begin
        chk("hold_valid", io.out_valid, 1, 0);
        chk("hold_re", $signed(io.out_re), $signed(hre), 0);
        chk("hold_im", $signed(io.out_im), $signed(him), 0);
        chk("hold_last", io.out_last, hlast, 0);
      end else if (n == hold_n && io.out_valid) begin
        held  = 1;
        hre   = io.out_re;
        him   = io.out_im;
        hlast = io.out_last;
      end
      if (n == hold_n && held && !io.out_ready) h++;
      if (io.out_valid && io.out_ready) begin
        got_re[n] = $signed(io.out_re);
        got_im[n] = $signed(io.out_im);
        chk($sformatf("out_last[%0d]", n), io.out_last, (n == 7), 0);
        n++;
      end
      @(posedge clk); #1;
      t++;
    end
    io.out_ready = 1'b0;
    chk("unload_count", n, 8, 0);
  endtask

  task automatic check_table(input int i);
    longint er, ei;
    for (int n = 0; n < 8; n++) begin
      er = $signed(tbl[i].er[n]);
      ei = $signed(tbl[i].ei[n]);
`ifdef IFFT8_SCALE_EN
      er = er >>> 3;
      ei = ei >>> 3;
`endif
      chk($sformatf("tbl%0d_re[%0d]", i, n), got_re[n], er, 0);
      chk($sformatf("tbl%0d_im[%0d]", i, n), got_im[n], ei, 0);
    end
  endtask

  // x[n] = sum_k X[k] e^{+j 2 pi k n / 8}, divided by 8 in the scaled build
  task automatic check_model(input string tag, input real tol);
    real c [8];
    real s [8];
    real c45, re, im;
    int  m;
    c45 = 0.7071067811865476;
    c[0] = 1.0;  c[1] = c45;  c[2] = 0.0;  c[3] = -c45;
    c[4] = -1.0; c[5] = -c45; c[6] = 0.0;  c[7] = c45;
    s[0] = 0.0;  s[1] = c45;  s[2] = 1.0;  s[3] = c45;
    s[4] = 0.0;  s[5] = -c45; s[6] = -1.0; s[7] = -c45;
    for (int n = 0; n < 8; n++) begin
      re = 0.0;
      im = 0.0;
      for (int k = 0; k < 8; k++) begin
        m  = (k * n) % 8;
        re = re + real'(x_re[k]) * c[m] - real'(x_im[k]) * s[m];
        im = im + real'(x_re[k]) * s[m] + real'(x_im[k]) * c[m];
      end
`ifdef IFFT8_SCALE_EN
      re = re / 8.0;
      im = im / 8.0;
`endif
      chk_r($sformatf("%s_re[%0d]", tag, n), got_re[n], re, tol);
      chk_r($sformatf("%s_im[%0d]", tag, n), got_im[n], im, tol);
    end
  endtask

  task automatic set_table(input int i);
    for (int k = 0; k < 8; k++) begin
      x_re[k] = $signed(tbl[i].xr[k]);
      x_im[k] = $signed(tbl[i].xi[k]);
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < 8; k++) begin
      x_re[k] = rnd();
      x_im[k] = rnd();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, na;
    int prev_first;
    a  = 32'h0008_0000;
    na = -a;
    for (int i = 0; i < 5; i++) tbl[i] = '0;
    tbl[0].xr[0] = a;
    tbl[2].xr[2] = a;
    tbl[3].xr[4] = a;
    tbl[4].xi[0] = a;
    tbl[1].er[0] = 32'h0008_0000;
    for (int n = 0; n < 8; n++) begin
      tbl[0].er[n] = a;
      tbl[1].xr[n] = 32'h0001_0000;
      case (n % 4)
        0:       tbl[2].er[n] = a;
        1:       tbl[2].ei[n] = a;
        2:       tbl[2].er[n] = na;
        default: tbl[2].ei[n] = na;
      endcase
      tbl[3].er[n] = (n % 2 == 1) ? na : a;
      tbl[4].ei[n] = a;
    end

    io.in_valid  = 1'b0;
    io.in_re     = '0;
    io.in_im     = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", io.in_ready, 1, 0);
    chk("rst_out_valid", io.out_valid, 0, 0);
    chk("rst_out_last", io.out_last, 0, 0);
    chk("rst_busy", busy, 0, 0);
    chk("rst_out_re", io.out_re, 0, 0);
    chk("rst_out_im", io.out_im, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    prev_first = 0;
    for (int i = 0; i < 5; i++) begin
      set_table(i);
      load_frame(0);
      unload_frame(0, -1);
      chk($sformatf("latency_tbl%0d", i), lat, 13, 0);
      check_table(i);
      if (i == 1) chk("frame_period", first_hs - prev_first, 28, 0);
      prev_first = first_hs;
    end

    for (int k = 0; k < 8; k++) begin
      x_re[k] = 0;
      x_im[k] = 0;
    end
    x_re[1] = 32'h0008_0000;
    load_frame(0);
    unload_frame(0, -1);
    check_model("bin1", 2.0);

    set_random();
    load_frame(0);
    unload_frame(0, 3);
    check_model("hold", 16.0);

    set_random();
    load_frame(0);
    unload_frame(0, -1);
    check_model("nogap", 16.0);
    for (int n = 0; n < 8; n++) begin
      sav_re[n] = got_re[n];
      sav_im[n] = got_im[n];
    end
    load_frame(40);
    unload_frame(0, -1);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("gap_same_re[%0d]", n), got_re[n], sav_re[n], 0);
      chk($sformatf("gap_same_im[%0d]", n), got_im[n], sav_im[n], 0);
    end

    for (int f = 0; f < 4; f++) begin
      set_random();
      load_frame(30);
      unload_frame(30, -1);
      chk($sformatf("latency_rnd%0d", f), lat, 13, 0);
      check_model($sformatf("rnd%0d", f), 16.0);
    end

    set_random();
    load_frame(0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_before", busy, 1, 0);
    chk("abort_in_ready_before", io.in_ready, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", busy, 0, 0);
    chk("abort_in_ready_after", io.in_ready, 1, 0);
    chk("abort_out_valid_after", io.out_valid, 0, 0);
    @(posedge clk); #1;
    set_table(0);
    load_frame(0);
    unload_frame(0, -1);
    chk("latency_after_abort", lat, 13, 0);
    check_table(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
